acc_cpu_core: RTL

//  Clocked, parametrised successor to the 8-bit combinational accumulator CPU datapath.

---
 rtl/acc_cpu_pkg.sv | 41 ++++
 rtl/acc_cpu_mul_seq.sv | 55 +++++
 rtl/acc_cpu_core.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/acc_cpu_pkg.sv
// rtl/acc_cpu_pkg.sv - shared opcodes, state encoding and instruction field helpers
package acc_cpu_pkg;

   // Opcode values carried in the top four instruction bits; 7..15 pass A through
   localparam logic [3:0] OPC_ADD = 4'd0;
   localparam logic [3:0] OPC_MUL = 4'd1;
   localparam logic [3:0] OPC_AND = 4'd2;
   localparam logic [3:0] OPC_OR  = 4'd3;
   localparam logic [3:0] OPC_NOT = 4'd4;
   localparam logic [3:0] OPC_SUB = 4'd5;
   localparam logic [3:0] OPC_LDI = 4'd6;

   // Core control states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   // Instruction layout, LSB first: imm, ridx, wb, opc[3:0]
   function automatic int f_imm_lsb();
      return 0;
   endfunction

   function automatic int f_ridx_lsb(input int imm_w);
      return imm_w;
   endfunction

   function automatic int f_wb_bit(input int imm_w, input int ridx_w);
      return imm_w + ridx_w;
   endfunction

   function automatic int f_opc_lsb(input int imm_w, input int ridx_w);
      return imm_w + ridx_w + 1;
   endfunction

   function automatic int f_instr_w(input int imm_w, input int ridx_w);
      return 4 + 1 + ridx_w + imm_w;
   endfunction

endpackage

// File: rtl/acc_cpu_mul_seq.sv
// rtl/acc_cpu_mul_seq.sv - iterative shift-add multiplier, one partial product per cycle
module acc_cpu_mul_seq
#(
   parameter int DATA_W = 8
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [DATA_W-1:0]     i_a,
   input  logic [DATA_W-1:0]     i_b,
   output logic                  o_done,
   output logic [2*DATA_W-1:0]   o_product
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [2*DATA_W-1:0] r_mcand;
   logic [DATA_W-1:0]   r_mplier;
   logic [2*DATA_W-1:0] r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_busy;

   // Load operands on start, then consume one multiplier bit per cycle until the count runs out
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
      end else if (i_start) begin
         r_mcand  <= (2*DATA_W)'(i_a);
         r_mplier <= i_b;
         r_acc    <= '0;
         r_cnt    <= CNT_W'(DATA_W);
         r_busy   <= 1'b1;
      end else if (r_busy) begin
         if (r_cnt != '0) begin
            if (r_mplier[0]) begin
               r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CNT_W'(1);
         end else begin
            // Done was presented this cycle; the consumer takes it on this edge
            r_busy <= 1'b0;
         end
      end
   end

   assign o_done    = r_busy && (r_cnt == '0);
   assign o_product = r_acc;

endmodule

// File: rtl/acc_cpu_core.sv
// rtl/acc_cpu_core.sv - clocked accumulator CPU core with register file, ALU and stream handshakes
module acc_cpu_core
   import acc_cpu_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int IMM_W    = 4,
   parameter  int NUM_REGS = 4,
   localparam int RIDX_W   = $clog2(NUM_REGS),
   localparam int INSTR_W  = f_instr_w(IMM_W, RIDX_W)
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic [INSTR_W-1:0]  instr,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [DATA_W-1:0]   res_data,
   output logic                res_carry,
   output logic                res_zero,
   input  logic [RIDX_W-1:0]   dbg_sel,
   output logic [DATA_W-1:0]   dbg_data,
   output logic                busy
);

   localparam int IMM_LSB  = f_imm_lsb();
   localparam int RIDX_LSB = f_ridx_lsb(IMM_W);
   localparam int WB_BIT   = f_wb_bit(IMM_W, RIDX_W);
   localparam int OPC_LSB  = f_opc_lsb(IMM_W, RIDX_W);

   state_t               r_state;
   logic [DATA_W-1:0]    r_regs [NUM_REGS];
   logic                 r_wb;
   logic [RIDX_W-1:0]    r_ridx;
   logic                 r_res_valid;
   logic [DATA_W-1:0]    r_res_data;
   logic                 r_res_carry;
   logic                 r_res_zero;

   logic [3:0]           w_opc;
   logic                 w_wb;
   logic [RIDX_W-1:0]    w_ridx;
   logic [IMM_W-1:0]     w_imm;
   logic [DATA_W-1:0]    w_a;
   logic [DATA_W-1:0]    w_b;
   logic [DATA_W:0]      w_sum;
   logic [DATA_W:0]      w_diff;
   logic [DATA_W-1:0]    w_alu_res;
   logic                 w_alu_carry;
   logic                 w_accept;
   logic                 w_mul_start;
   logic                 w_mul_done;
   logic [2*DATA_W-1:0]  w_mul_product;
   logic [DATA_W-1:0]    w_mul_lo;
   logic                 w_mul_carry;

   assign w_opc  = instr[OPC_LSB +: 4];
   assign w_wb   = instr[WB_BIT];
   assign w_ridx = instr[RIDX_LSB +: RIDX_W];
   assign w_imm  = instr[IMM_LSB +: IMM_W];

   assign w_a    = r_regs[w_ridx];
   assign w_b    = DATA_W'(w_imm);
   assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
   assign w_diff = {1'b0, w_a} - {1'b0, w_b};

   assign w_accept    = instr_valid && (r_state == ST_IDLE);
   assign w_mul_start = w_accept && (w_opc == OPC_MUL);
   assign w_mul_lo    = w_mul_product[DATA_W-1:0];
   assign w_mul_carry = |w_mul_product[2*DATA_W-1:DATA_W];

   // Single-cycle ALU on the instruction currently offered; MUL is handled by the sequencer
   always_comb begin
      w_alu_res   = w_a;
      w_alu_carry = 1'b0;
      case (w_opc)
         OPC_ADD: {w_alu_carry, w_alu_res} = w_sum;
         OPC_SUB: {w_alu_carry, w_alu_res} = w_diff;
         OPC_AND: w_alu_res = w_a & w_b;
         OPC_OR:  w_alu_res = w_a | w_b;
         OPC_NOT: w_alu_res = ~w_a;
         OPC_LDI: w_alu_res = w_b;
         default: w_alu_res = w_a;
      endcase
   end

   acc_cpu_mul_seq #(
      .DATA_W    (DATA_W)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_mul_start),
      .i_a       (w_a),
      .i_b       (w_b),
      .o_done    (w_mul_done),
      .o_product (w_mul_product)
   );

   // Control FSM with register-file write-back and registered result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_wb        <= 1'b0;
         r_ridx      <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_carry <= 1'b0;
         r_res_zero  <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_wb   <= w_wb;
                  r_ridx <= w_ridx;
                  if (w_opc == OPC_MUL) begin
                     r_state <= ST_MUL;
                  end else begin
                     r_res_data  <= w_alu_res;
                     r_res_carry <= w_alu_carry;
                     r_res_zero  <= (w_alu_res == '0);
                     r_res_valid <= 1'b1;
                     if (w_wb) begin
                        r_regs[w_ridx] <= w_alu_res;
                     end
                     r_state <= ST_OUT;
                  end
               end
            end
            ST_MUL: begin
               if (w_mul_done) begin
                  r_res_data  <= w_mul_lo;
                  r_res_carry <= w_mul_carry;
                  r_res_zero  <= (w_mul_lo == '0);
                  r_res_valid <= 1'b1;
                  if (r_wb) begin
                     r_regs[r_ridx] <= w_mul_lo;
                  end
                  r_state <= ST_OUT;
               end
            end
            ST_OUT: begin
               // Result fields keep their last value after the handshake
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign instr_ready = (r_state == ST_IDLE);
   assign busy        = (r_state != ST_IDLE);
   assign res_valid   = r_res_valid;
   assign res_data    = r_res_data;
   assign res_carry   = r_res_carry;
   assign res_zero    = r_res_zero;
   assign dbg_data    = r_regs[dbg_sel];

endmodule
